regfile_writeback: RTL and testbench

- Write-back stage directly upstream of the 32x32 register file RAM. It is the sole driver of the RAM's wren/wraddress/data.
- Merges two result sources into the single RAM write port:
  - ALU results, in-order, never stalled.
  - Load returns from the memory interface, out of band, buffered in a small FIFO.
- Keeps a pending-load scoreboard (busy mask) that the decode stage uses for RAW/WAW stalls.

---
 rtl/regfile_writeback.sv | 153 +++++++++++++++
 tb/tb_regfile_writeback.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Write-back stage in front of the 32x32 register-file RAM. It is the only
// driver of the RAM write port. ALU results always take the port when they
// target a real register. Load returns from memory are buffered in a small
// in-order FIFO and drain whenever the ALU leaves the port idle. A load return
// arriving while the FIFO is empty and the port is free goes straight to the
// outputs. A pending-load scoreboard (busy) is kept for decode RAW/WAW stalls.
//
// Ports
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   alu_valid/rd/data       in-order ALU result, never back-pressured
//   ld_issue/ld_issue_rd    load issued this cycle; marks its rd busy
//   mem_valid/rd/data       returning load data
//   mem_ready               return accepted (depends only on registered count)
//   wren/wraddress/wrdata   registered RAM write port (latency 1)
//   busy                    bit r set = load to register r still outstanding
//   fifo_count              current FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             ld_issue,
  input  logic [4:0]       ld_issue_rd,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_data,
  output logic             mem_ready,
  output logic             wren,
  output logic [4:0]       wraddress,
  output logic [31:0]      wrdata,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int              PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wren_q, wren_d;
  logic [4:0]       wraddress_q, wraddress_d;
  logic [31:0]      wrdata_q, wrdata_d;
  logic [31:0]      busy_q, busy_d;

  logic   alu_win;
  logic   fifo_empty;
  logic   mem_xfer;
  logic   mem_write;
  logic   pop;
  logic   bypass;
  logic   push;
  entry_t head;

  // Ready comes from the registered count only, so a pop in the same cycle
  // cannot make room for a return that arrives while the FIFO is full.
  assign mem_ready  = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign mem_xfer   = mem_valid && mem_ready;
  // A return to x0 is accepted but dropped: it is neither queued nor written.
  assign mem_write  = mem_xfer && (mem_rd != 5'd0);
  assign alu_win    = alu_valid && (alu_rd != 5'd0);
  assign pop        = !alu_win && !fifo_empty;
  // Bypass only when nothing is queued, so a later return never overtakes.
  assign bypass     = !alu_win && fifo_empty && mem_write;
  assign push       = mem_write && !bypass;
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wren_d      = 1'b0;
    wraddress_d = wraddress_q;
    wrdata_d    = wrdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    busy_d      = busy_q;

    if (alu_win) begin
      wren_d      = 1'b1;
      wraddress_d = alu_rd;
      wrdata_d    = alu_data;
    end else if (pop) begin
      wren_d      = 1'b1;
      wraddress_d = head.rd;
      wrdata_d    = head.data;
    end else if (bypass) begin
      wren_d      = 1'b1;
      wraddress_d = mem_rd;
      wrdata_d    = mem_data;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Clear on the edge the RAM commits the registered write; a new issue to
    // the same register in that cycle is applied afterwards and so wins.
    if (wren_q)   busy_d[wraddress_q] = 1'b0;
    if (ld_issue) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wren_q      <= 1'b0;
      wraddress_q <= '0;
      wrdata_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
    end else begin
      wren_q      <= wren_d;
      wraddress_q <= wraddress_d;
      wrdata_q    <= wrdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is not reset: clearing the pointers and count discards contents.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
  end

  assign wren       = wren_q;
  assign wraddress  = wraddress_q;
  assign wrdata     = wrdata_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          ld_issue;
  logic [4:0]    ld_issue_rd;
  logic          mem_valid;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_data;
  logic          mem_ready;
  logic          wren;
  logic [4:0]    wraddress;
  logic [31:0]   wrdata;
  logic [31:0]   busy;
  logic [CW-1:0] fifo_count;

  regfile_writeback #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_issue   (ld_issue),
    .ld_issue_rd(ld_issue_rd),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .wren       (wren),
    .wraddress  (wraddress),
    .wrdata     (wrdata),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst_n;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] ad;
    bit          ld;
    logic [4:0]  lrd;
    bit          mv;
    logic [4:0]  mrd;
    logic [31:0] md;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          e_ready;
    bit          e_wren;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_busy;
    int          e_cnt;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: a queue of pending returns, a busy mask and the
  // last write presented to the RAM.
  ent_t        mq[$];
  logic [31:0] m_busy;
  bit          m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          model_valid = 0;

  int checks = 0;
  int errors = 0;
  bit last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(bit rst_n, bit av, logic [4:0] ard, logic [31:0] ad,
                               bit ld, logic [4:0] lrd,
                               bit mv, logic [4:0] mrd, logic [31:0] md);
    stim_t s;
    s.rst_n = rst_n; s.av = av; s.ard = ard; s.ad = ad;
    s.ld = ld; s.lrd = lrd; s.mv = mv; s.mrd = mrd; s.md = md;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic model_update(input stim_t s);
    bit          xfer;
    bit          bypassed;
    logic [31:0] nb;
    ent_t        e;
    if (!s.rst_n) begin
      mq.delete();
      m_busy = 0; m_wren = 0; m_addr = 0; m_data = 0;
      return;
    end
    xfer     = s.mv && (mq.size() != DEPTH);
    bypassed = 0;
    nb       = m_busy;
    if (m_wren) nb[m_addr] = 1'b0;
    if (s.ld && s.lrd != 0) nb[s.lrd] = 1'b1;
    if (s.av && s.ard != 0) begin
      m_wren = 1; m_addr = s.ard; m_data = s.ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wren = 1; m_addr = e.rd; m_data = e.data;
    end else if (xfer && s.mrd != 0) begin
      m_wren = 1; m_addr = s.mrd; m_data = s.md; bypassed = 1;
    end else begin
      m_wren = 0;
    end
    if (xfer && s.mrd != 0 && !bypassed) mq.push_back('{rd: s.mrd, data: s.md});
    m_busy = nb;
  endtask

  // One clock transaction: drive, check ready before the edge, update the
  // model at the edge and compare every output just after it.
  task automatic step(input stim_t s);
    reset_n = s.rst_n; alu_valid = s.av; alu_rd = s.ard; alu_data = s.ad;
    ld_issue = s.ld; ld_issue_rd = s.lrd;
    mem_valid = s.mv; mem_rd = s.mrd; mem_data = s.md;
    @(negedge clock);
    last_ready = mem_ready;
    if (model_valid) chk("model_mem_ready", 32'(mem_ready), 32'(mq.size() != DEPTH));
    @(posedge clock);
    #1;
    model_update(s);
    if (!s.rst_n) model_valid = 1;
    if (model_valid) begin
      chk("model_wren", 32'(wren), 32'(m_wren));
      chk("model_wraddress", 32'(wraddress), 32'(m_addr));
      chk("model_wrdata", wrdata, m_data);
      chk("model_busy", busy, m_busy);
      chk("model_fifo_count", 32'(fifo_count), 32'(mq.size()));
    end
    $display("t=%0t rst_n=%b alu=%b/%0d ld=%b/%0d mem=%b/%0d rdy=%b -> wren=%b wa=%0d wd=%h busy=%h cnt=%0d",
             $time, s.rst_n, s.av, s.ard, s.ld, s.lrd, s.mv, s.mrd, last_ready,
             wren, wraddress, wrdata, busy, fifo_count);
  endtask

  vec_t vecs[10];

  initial begin
    stim_t s;
    int    mi;

    // Directed table: expected values after each edge.
    vecs[0] = '{mk(0,0,0,0,0,0,0,0,0),              1, 0, 0, 32'h0,        32'h0,   0};
    vecs[1] = '{idle(),                              1, 0, 0, 32'h0,        32'h0,   0};
    vecs[2] = '{mk(1,1,3,32'h11,0,0,1,4,32'h22),     1, 1, 3, 32'h11,       32'h0,   1};
    vecs[3] = '{idle(),                              1, 1, 4, 32'h22,       32'h0,   0};
    vecs[4] = '{mk(1,1,0,32'h55,0,0,0,0,0),          1, 0, 4, 32'h22,       32'h0,   0};
    vecs[5] = '{mk(1,0,0,0,1,0,0,0,0),               1, 0, 4, 32'h22,       32'h0,   0};
    vecs[6] = '{mk(1,0,0,0,0,0,1,0,32'h77),          1, 0, 4, 32'h22,       32'h0,   0};
    vecs[7] = '{mk(1,0,0,0,1,9,0,0,0),               1, 0, 4, 32'h22,       32'h200, 0};
    vecs[8] = '{mk(1,0,0,0,0,0,1,9,32'hCAFE),        1, 1, 9, 32'hCAFE,     32'h200, 0};
    vecs[9] = '{idle(),                              1, 0, 9, 32'hCAFE,     32'h0,   0};

    // Initial reset, then idle five cycles.
    step(mk(0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 5; i++) begin
      step(idle());
      chk("idle_wren", 32'(wren), 32'd0);
      chk("idle_busy", busy, 32'd0);
      chk("idle_count", 32'(fifo_count), 32'd0);
      chk("idle_ready", 32'(last_ready), 32'd1);
    end

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].s);
      chk($sformatf("vec%0d_ready", i), 32'(last_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_wren", i), 32'(wren), 32'(vecs[i].e_wren));
      chk($sformatf("vec%0d_wraddress", i), 32'(wraddress), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_wrdata", i), wrdata, vecs[i].e_data);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
    end

    // Load to r5 returns three cycles after issue and bypasses.
    step(mk(0,0,0,0,0,0,0,0,0));
    step(mk(1,0,0,0,1,5,0,0,0));
    chk("ld5_busy_set", busy, 32'h20);
    step(idle());
    step(idle());
    step(mk(1,0,0,0,0,0,1,5,32'hDEADBEEF));
    chk("ld5_wren", 32'(wren), 32'd1);
    chk("ld5_wraddress", 32'(wraddress), 32'd5);
    chk("ld5_wrdata", wrdata, 32'hDEADBEEF);
    chk("ld5_busy_still", busy, 32'h20);
    step(idle());
    chk("ld5_busy_clear", busy, 32'h0);
    chk("ld5_wren_off", 32'(wren), 32'd0);

    // ALU every cycle while five returns arrive back to back.
    step(mk(0,0,0,0,0,0,0,0,0));
    mi = 0;
    for (int c = 0; c < 8; c++) begin
      step(mk(1,1,5'(c+1),32'(100+c),0,0, mi < 5, 5'(10+mi), 32'h1000 + 32'(mi)));
      if (c == 4) chk("b2b_full_ready", 32'(last_ready), 32'd0);
      if (mi < 5 && last_ready) mi++;
    end
    chk("b2b_count_full", 32'(fifo_count), 32'(DEPTH));
    for (int i = 0; i < 5; i++) begin
      step(mk(1,0,0,0,0,0, mi < 5, 5'(10+mi), 32'h1000 + 32'(mi)));
      if (mi < 5 && last_ready) mi++;
      chk($sformatf("drain%0d_wren", i), 32'(wren), 32'd1);
      chk($sformatf("drain%0d_wraddress", i), 32'(wraddress), 32'(10+i));
      chk($sformatf("drain%0d_wrdata", i), wrdata, 32'h1000 + 32'(i));
    end
    chk("drain_empty", 32'(fifo_count), 32'd0);

    // FIFO pops r7; a new load to r7 issues on the commit edge.
    step(mk(0,0,0,0,0,0,0,0,0));
    step(mk(1,0,0,0,1,7,0,0,0));
    step(mk(1,1,1,32'h1,0,0,1,7,32'h77));
    chk("conf_count", 32'(fifo_count), 32'd1);
    step(idle());
    chk("conf_pop_addr", 32'(wraddress), 32'd7);
    chk("conf_pop_wren", 32'(wren), 32'd1);
    step(mk(1,0,0,0,1,7,0,0,0));
    chk("conf_busy_setwins", busy, 32'h80);
    step(idle());
    chk("conf_busy_hold", busy, 32'h80);

    // Reset while the FIFO holds three entries.
    step(mk(0,0,0,0,0,0,0,0,0));
    step(mk(1,0,0,0,1,20,0,0,0));
    for (int i = 0; i < 3; i++) step(mk(1,1,5'(i+1),32'(i),0,0,1,5'(20+i),32'(i+500)));
    chk("rst3_count_before", 32'(fifo_count), 32'd3);
    step(mk(0,0,0,0,0,0,1,23,32'h9));
    chk("rst3_count", 32'(fifo_count), 32'd0);
    chk("rst3_busy", busy, 32'd0);
    chk("rst3_wren", 32'(wren), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(idle());
      chk("rst3_no_write", 32'(wren), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      s = mk($urandom_range(99) != 0, $urandom_range(1) == 1, 5'($urandom_range(31)),
             $urandom, $urandom_range(3) == 0, 5'($urandom_range(31)),
             $urandom_range(3) != 0, 5'($urandom_range(31)), $urandom);
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
